// File: rtl/pbc_pkg.sv
// Shared types and constants for the product/box counter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pbc_pkg;

    typedef enum logic {
        COUNTING = 1'b0,
        FULL     = 1'b1
    } state_e;

    // Active-low segments, bit6 = a .. bit0 = g.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Legal parameter ranges.
    localparam int ITEMS_MIN = 2;
    localparam int ITEMS_MAX = 99;
    localparam int BOXES_MIN = 1;
    localparam int BOXES_LIM = 99;
    localparam int DEB_MIN   = 1;
    localparam int DEB_MAX   = 255;

    // Two-digit BCD to binary; result is at most 99 so 7 bits suffice.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] hi, input logic [3:0] lo);
        return ({3'b000, hi} * 7'd10) + {3'b000, lo};
    endfunction

    // Two-digit BCD increment, returned as {hi, lo}.
    function automatic logic [7:0] bcd_inc(input logic [3:0] hi, input logic [3:0] lo);
        if (lo == 4'd9) begin
            return {hi + 4'd1, 4'd0};
        end
        return {hi, lo + 4'd1};
    endfunction

endpackage

// File: rtl/product_box_counter_seg7_decoder.sv
// One BCD digit to an active-low 7-segment pattern, with forced blanking.
// Latency: combinational.
// Backpressure: none; pure decode.
module seg7_decoder
    import pbc_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Decode digit; blank flag or a non-decimal code turns every segment off.
    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/product_box_counter.sv
// Item/box counter from an async sensor, stops when BOXES_MAX boxes are done; macro DEBOUNCE_EN adds a debouncer.
// Latency: sensor rise sampled at edge k updates counts after edge k+2 (+DEB_CYCLES with DEBOUNCE_EN).
// Backpressure: none; the sensor cannot be stalled, items arriving while FULL are dropped and flagged in item_lost.
module product_box_counter
    import pbc_pkg::*;
#(
    parameter int ITEMS_PER_BOX = 10,
    parameter int BOXES_MAX     = 9,
    parameter int DEB_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       item_in,
    input  logic       ack_full,
    output logic [6:0] seg_item_lo,
    output logic [6:0] seg_item_hi,
    output logic [6:0] seg_box_lo,
    output logic [6:0] seg_box_hi,
    output logic [6:0] item_cnt,
    output logic [6:0] box_cnt,
    output logic       box_done,
    output logic       full,
    output logic       item_lost
);

    if (ITEMS_PER_BOX < ITEMS_MIN || ITEMS_PER_BOX > ITEMS_MAX) begin : g_bad_items
        $error("product_box_counter: ITEMS_PER_BOX out of range 2..99");
    end
    if (BOXES_MAX < BOXES_MIN || BOXES_MAX > BOXES_LIM) begin : g_bad_boxes
        $error("product_box_counter: BOXES_MAX out of range 1..99");
    end
    if (DEB_CYCLES < DEB_MIN || DEB_CYCLES > DEB_MAX) begin : g_bad_deb
        $error("product_box_counter: DEB_CYCLES out of range 1..255");
    end

    localparam logic [6:0] ITEM_LAST = 7'(ITEMS_PER_BOX - 1);
    localparam logic [6:0] BOX_LAST  = 7'(BOXES_MAX);

    logic       sync1_q, sync2_q, hist_q;
    logic       level;
    logic       item_evt;
    state_e     state_q, state_d;
    logic [3:0] item_hi_q, item_lo_q, item_hi_d, item_lo_d;
    logic [3:0] box_hi_q, box_lo_q, box_hi_d, box_lo_d;
    logic       box_done_q, box_done_d;
    logic       lost_q, lost_d;
    logic [7:0] item_inc, box_inc;

`ifdef DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic       deb_q, deb_d;
    logic [7:0] deb_cnt_q, deb_cnt_d;

    // Debounce: adopt the synchronised level only after it has differed for DEB_CYCLES cycles.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 8'd1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign level = deb_q;
`else
    assign level = sync2_q;
`endif

    assign item_evt = level & ~hist_q;
    assign item_cnt = bcd_to_bin(item_hi_q, item_lo_q);
    assign box_cnt  = bcd_to_bin(box_hi_q, box_lo_q);
    assign item_inc = bcd_inc(item_hi_q, item_lo_q);
    assign box_inc  = bcd_inc(box_hi_q, box_lo_q);

    // Next-state: count items, roll into boxes, freeze in FULL until acknowledged.
    always_comb begin
        state_d    = state_q;
        item_hi_d  = item_hi_q;
        item_lo_d  = item_lo_q;
        box_hi_d   = box_hi_q;
        box_lo_d   = box_lo_q;
        box_done_d = 1'b0;
        lost_d     = lost_q;
        case (state_q)
            COUNTING: begin
                if (item_evt) begin
                    if (item_cnt == ITEM_LAST) begin
                        item_hi_d  = 4'd0;
                        item_lo_d  = 4'd0;
                        box_hi_d   = box_inc[7:4];
                        box_lo_d   = box_inc[3:0];
                        box_done_d = 1'b1;
                        if (bcd_to_bin(box_inc[7:4], box_inc[3:0]) == BOX_LAST) begin
                            state_d = FULL;
                        end
                    end else begin
                        item_hi_d = item_inc[7:4];
                        item_lo_d = item_inc[3:0];
                    end
                end
            end
            FULL: begin
                // Acknowledge wins over a coincident item, which is simply dropped.
                if (ack_full) begin
                    item_hi_d = 4'd0;
                    item_lo_d = 4'd0;
                    box_hi_d  = 4'd0;
                    box_lo_d  = 4'd0;
                    lost_d    = 1'b0;
                    state_d   = COUNTING;
                end else if (item_evt) begin
                    lost_d = 1'b1;
                end
            end
            default: state_d = COUNTING;
        endcase
    end

    // Synchroniser, edge history and counter state; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            hist_q     <= 1'b0;
            state_q    <= COUNTING;
            item_hi_q  <= 4'd0;
            item_lo_q  <= 4'd0;
            box_hi_q   <= 4'd0;
            box_lo_q   <= 4'd0;
            box_done_q <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            sync1_q    <= item_in;
            sync2_q    <= sync1_q;
            hist_q     <= level;
            state_q    <= state_d;
            item_hi_q  <= item_hi_d;
            item_lo_q  <= item_lo_d;
            box_hi_q   <= box_hi_d;
            box_lo_q   <= box_lo_d;
            box_done_q <= box_done_d;
            lost_q     <= lost_d;
        end
    end

    assign box_done  = box_done_q;
    assign full      = (state_q == FULL);
    assign item_lost = lost_q;

    seg7_decoder u_seg_item_lo (.digit_i(item_lo_q), .blank_i(1'b0),              .seg_o(seg_item_lo));
    seg7_decoder u_seg_item_hi (.digit_i(item_hi_q), .blank_i(item_hi_q == 4'd0), .seg_o(seg_item_hi));
    seg7_decoder u_seg_box_lo  (.digit_i(box_lo_q),  .blank_i(1'b0),              .seg_o(seg_box_lo));
    seg7_decoder u_seg_box_hi  (.digit_i(box_hi_q),  .blank_i(box_hi_q == 4'd0),  .seg_o(seg_box_hi));

endmodule

// File: tb/tb_product_box_counter.sv
// Self-checking bench: default instance plus a 12-per-box / 15-box instance.
// Expected values come from a pulse-count model (items = n % size, boxes = n / size).
module tb_product_box_counter;

    localparam int IPB_A = 10;
    localparam int BMX_A = 9;
    localparam int IPB_B = 12;
    localparam int BMX_B = 15;
`ifdef DEBOUNCE_EN
    localparam int EXTRA = 4;
`else
    localparam int EXTRA = 0;
`endif
    // Ticks after raising item_in that bring us just before the counting edge.
    localparam int LAT  = 2 + EXTRA;
    localparam int HOLD = LAT + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic item_a = 1'b0, ack_a = 1'b0, item_b = 1'b0, ack_b = 1'b0;
    logic [6:0] sil_a, sih_a, sbl_a, sbh_a, ic_a, bc_a;
    logic [6:0] sil_b, sih_b, sbl_b, sbh_b, ic_b, bc_b;
    logic       bd_a, full_a, lost_a, bd_b, full_b, lost_b;

    int n_pass = 0;
    int n_total = 0;
    int acc_a = 0;
    int acc_b = 0;
    bit mlost_a = 1'b0;
    int bd_seen = 0;

    always #5 clk = ~clk;

    product_box_counter #(.ITEMS_PER_BOX(IPB_A), .BOXES_MAX(BMX_A), .DEB_CYCLES(4)) u_dut_a (
        .clk(clk), .rst(rst), .item_in(item_a), .ack_full(ack_a),
        .seg_item_lo(sil_a), .seg_item_hi(sih_a), .seg_box_lo(sbl_a), .seg_box_hi(sbh_a),
        .item_cnt(ic_a), .box_cnt(bc_a), .box_done(bd_a), .full(full_a), .item_lost(lost_a));

    product_box_counter #(.ITEMS_PER_BOX(IPB_B), .BOXES_MAX(BMX_B), .DEB_CYCLES(4)) u_dut_b (
        .clk(clk), .rst(rst), .item_in(item_b), .ack_full(ack_b),
        .seg_item_lo(sil_b), .seg_item_hi(sih_b), .seg_box_lo(sbl_b), .seg_box_hi(sbh_b),
        .item_cnt(ic_b), .box_cnt(bc_b), .box_done(bd_b), .full(full_b), .item_lost(lost_b));

    // Count cycles with box_done high on instance A.
    always @(negedge clk) begin
        if (bd_a === 1'b1) bd_seen++;
    end

    function automatic logic [6:0] seg_digit(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] seg_hi(input int v);
        return (v < 10) ? 7'b1111111 : seg_digit(v / 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag);
        int it, bx;
        it = acc_a % IPB_A;
        bx = acc_a / IPB_A;
        @(negedge clk);
        chk({tag, ".item_cnt"}, 32'(ic_a), it);
        chk({tag, ".box_cnt"},  32'(bc_a), bx);
        chk({tag, ".full"},     32'(full_a), (bx == BMX_A) ? 1 : 0);
        chk({tag, ".item_lost"}, 32'(lost_a), 32'(mlost_a));
        chk({tag, ".seg_item_lo"}, 32'(sil_a), 32'(seg_digit(it % 10)));
        chk({tag, ".seg_item_hi"}, 32'(sih_a), 32'(seg_hi(it)));
        chk({tag, ".seg_box_lo"},  32'(sbl_a), 32'(seg_digit(bx % 10)));
        chk({tag, ".seg_box_hi"},  32'(sbh_a), 32'(seg_hi(bx)));
    endtask

    task automatic pulse_a();
        int unsigned h, l;
        h = $urandom_range(HOLD + 2, HOLD);
        l = $urandom_range(HOLD + 2, HOLD);
        item_a = 1'b1;
        repeat (h) tick();
        item_a = 1'b0;
        repeat (l) tick();
        if (acc_a / IPB_A >= BMX_A) mlost_a = 1'b1;
        else acc_a++;
    endtask

    task automatic pulse_b();
        int unsigned h, l;
        h = $urandom_range(HOLD + 2, HOLD);
        l = $urandom_range(HOLD + 2, HOLD);
        item_b = 1'b1;
        repeat (h) tick();
        item_b = 1'b0;
        repeat (l) tick();
        if (acc_b / IPB_B < BMX_B) acc_b++;
    endtask

    initial begin
        int bd0;
        // Reset.
        repeat (3) tick();
        rst = 1'b0;
        check_a("reset");
        chk("reset.box_done", 32'(bd_a), 0);
        chk("reset_b.item_cnt", 32'(ic_b), 0);
        chk("reset_b.seg_box_hi", 32'(sbh_b), 32'h7f);

        // Nine items, then the tenth completes a box.
        repeat (9) pulse_a();
        check_a("nine");
        bd0 = bd_seen;
        pulse_a();
        check_a("ten");
        chk("ten.box_done_cycles", bd_seen - bd0, 1);

        repeat (15) pulse_a();
        check_a("twentyfive");
        chk("twentyfive.box_done_cycles", bd_seen, 2);

        // Acknowledge while counting has no effect.
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        check_a("ack_counting");

        // Fill up to FULL, then items are lost.
        repeat (65) pulse_a();
        check_a("full");
        repeat (3) pulse_a();
        check_a("lost");
        chk("lost.box_done_cycles", bd_seen, 9);

        // Acknowledge coincident with an item edge: item dropped, everything cleared.
        item_a = 1'b1;
        repeat (LAT) tick();
        ack_a = 1'b1;
        tick();
        ack_a = 1'b0;
        item_a = 1'b0;
        acc_a = 0;
        mlost_a = 1'b0;
        repeat (HOLD) tick();
        check_a("ack_full");

        // Exact latency of one item.
        item_a = 1'b1;
        repeat (LAT) tick();
        @(negedge clk);
        chk("latency.before", 32'(ic_a), 0);
        tick();
        @(negedge clk);
        chk("latency.after", 32'(ic_a), 1);
        item_a = 1'b0;
        acc_a = 1;
        repeat (HOLD) tick();

`ifdef DEBOUNCE_EN
        // Short glitch is ignored by the debouncer.
        item_a = 1'b1;
        repeat (2) tick();
        item_a = 1'b0;
        repeat (HOLD + 2) tick();
        check_a("glitch");
`endif

        // Reset mid-count on the same edge as an item event.
        repeat (6) pulse_a();
        check_a("seven");
        item_a = 1'b1;
        repeat (LAT) tick();
        @(negedge clk);
        chk("rst_edge.before", 32'(ic_a), 7);
        item_a = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        acc_a = 0;
        mlost_a = 1'b0;
        acc_b = 0;
        check_a("rst_edge");
        repeat (HOLD) tick();
        check_a("rst_edge.later");

        // Random pulses and acknowledges.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(7, 0) == 0) begin
                ack_a = 1'b1;
                tick();
                ack_a = 1'b0;
                if (acc_a / IPB_A == BMX_A) begin
                    acc_a = 0;
                    mlost_a = 1'b0;
                end
            end else begin
                pulse_a();
            end
            check_a("random");
        end

        // Second configuration: 12 per box, 150 items.
        repeat (150) pulse_b();
        @(negedge clk);
        chk("cfg12.box_cnt", 32'(bc_b), acc_b / IPB_B);
        chk("cfg12.item_cnt", 32'(ic_b), acc_b % IPB_B);
        chk("cfg12.seg_box_hi", 32'(sbh_b), 32'(seg_hi(acc_b / IPB_B)));
        chk("cfg12.seg_box_lo", 32'(sbl_b), 32'(seg_digit((acc_b / IPB_B) % 10)));
        chk("cfg12.seg_item_lo", 32'(sil_b), 32'(seg_digit(acc_b % IPB_B % 10)));
        chk("cfg12.full", 32'(full_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
